fish_round_sequencer: RTL and testbench



---
 rtl/fish_game_pkg.sv | 23 ++
 rtl/sec_tick_gen.sv | 37 +++
 rtl/fish_round_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_fish_round_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fish_game_pkg.sv
// Shared types and constants for the fishing game: round FSM states,
// per-level fish table and screen geometry.
package fish_game_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SPAWN,
      PLAY,
      REEL,
      DONE,
      WIN,
      LOSE
   } state_t;

   // Index 0 is the least significant element, so FISH_Y[level] is the level entry.
   localparam logic [3:0][9:0] FISH_Y   = {10'd200, 10'd290, 10'd380, 10'd470};
   localparam logic [3:0][5:0] FISH_W   = {6'd10, 6'd20, 6'd40, 6'd60};
   localparam logic [3:0][2:0] FISH_SPD = {3'd4, 3'd3, 3'd2, 3'd1};

   localparam logic [9:0] WATER_LINE = 10'd155;
   localparam logic [9:0] RIGHT_EDGE = 10'd798;

endpackage

// File: rtl/sec_tick_gen.sv
// Divides game ticks into one-second pulses; clr restarts the count and
// hold freezes it. sec is combinational so the consumer acts on the same tick.
module sec_tick_gen #(
   parameter int TICKS_PER_SEC = 60
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic hold,
   input  logic tick,
   output logic sec
);

   localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          adv;

   always_comb begin
      adv   = tick & ~hold;
      sec   = adv & (cnt_q == LAST);
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (adv)
         cnt_d = sec ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/fish_round_sequencer.sv
// Game-level controller: sequences four fish rounds, owns timer, misses,
// score and outcome. Optional pause input when FISH_PAUSE_EN is defined.
module fish_round_sequencer
   import fish_game_pkg::*;
#(
   parameter int TICKS_PER_SEC = 60,
   parameter int LEVEL_TIME    = 30,
   parameter int MAX_MISSES    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic       hooked,
   input  logic       landed,
   input  logic       escaped,
`ifdef FISH_PAUSE_EN
   input  logic       pause,
`endif
   output logic [1:0] level,
   output logic [9:0] fish_y,
   output logic [5:0] fish_w,
   output logic [2:0] fish_speed,
   output logic       spawn,
   output logic       play_en,
   output logic [6:0] time_left,
   output logic [2:0] misses,
   output logic [7:0] score,
   output logic       win,
   output logic       lose
);

   localparam logic [6:0] TIME_RELOAD = 7'(LEVEL_TIME);
   localparam logic [2:0] MISS_LIMIT  = 3'(MAX_MISSES);

   state_t     state_q, state_d;
   logic [1:0] level_q, level_d;
   logic [9:0] fish_y_q, fish_y_d;
   logic [5:0] fish_w_q, fish_w_d;
   logic [2:0] fish_speed_q, fish_speed_d;
   logic       spawn_q, spawn_d;
   logic       play_en_q, play_en_d;
   logic [6:0] time_left_q, time_left_d;
   logic [2:0] misses_q, misses_d;
   logic [7:0] score_q, score_d;
   logic       win_q, win_d;
   logic       lose_q, lose_d;

   logic       pause_w, frozen, sec_clr, sec_hold, sec;
   logic [8:0] score_sum;

`ifdef FISH_PAUSE_EN
   assign pause_w = pause;
`else
   assign pause_w = 1'b0;
`endif

   sec_tick_gen #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_sec (
      .clk (clk),
      .rst (rst),
      .clr (sec_clr),
      .hold(sec_hold),
      .tick(tick),
      .sec (sec)
   );

   always_comb begin
      state_d      = state_q;
      level_d      = level_q;
      fish_y_d     = fish_y_q;
      fish_w_d     = fish_w_q;
      fish_speed_d = fish_speed_q;
      time_left_d  = time_left_q;
      misses_d     = misses_q;
      score_d      = score_q;
      sec_clr      = 1'b0;
      frozen       = pause_w & ((state_q == PLAY) | (state_q == REEL));
      // The seconds counter only runs in an unpaused PLAY cycle with no hook.
      sec_hold     = ~((state_q == PLAY) & ~frozen & ~hooked);
      score_sum    = {1'b0, score_q} + {2'b00, time_left_q};

      case (state_q)
         IDLE, WIN, LOSE: begin
            if (start) begin
               level_d     = 2'd0;
               misses_d    = 3'd0;
               score_d     = 8'd0;
               time_left_d = TIME_RELOAD;
               sec_clr     = 1'b1;
               state_d     = SPAWN;
            end
         end
         SPAWN: state_d = PLAY;
         PLAY: begin
            if (!frozen) begin
               if (hooked)
                  state_d = REEL;
               else if (sec) begin
                  time_left_d = time_left_q - 7'd1;
                  if (time_left_q == 7'd1)
                     state_d = LOSE;
               end
            end
         end
         REEL: begin
            if (!frozen) begin
               if (landed)
                  state_d = DONE;
               else if (escaped) begin
                  misses_d = misses_q + 3'd1;
                  state_d  = (misses_d == MISS_LIMIT) ? LOSE : SPAWN;
               end
            end
         end
         DONE: begin
            score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
            if (level_q == 2'd3)
               state_d = WIN;
            else begin
               level_d     = level_q + 2'd1;
               time_left_d = TIME_RELOAD;
               sec_clr     = 1'b1;
               state_d     = SPAWN;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d == SPAWN) begin
         fish_y_d     = FISH_Y[level_d];
         fish_w_d     = FISH_W[level_d];
         fish_speed_d = FISH_SPD[level_d];
      end
      spawn_d   = (state_d == SPAWN);
      play_en_d = ((state_d == PLAY) | (state_d == REEL)) & ~pause_w;
      win_d     = (state_d == WIN);
      lose_d    = (state_d == LOSE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         level_q      <= 2'd0;
         fish_y_q     <= FISH_Y[0];
         fish_w_q     <= FISH_W[0];
         fish_speed_q <= FISH_SPD[0];
         spawn_q      <= 1'b0;
         play_en_q    <= 1'b0;
         time_left_q  <= TIME_RELOAD;
         misses_q     <= 3'd0;
         score_q      <= 8'd0;
         win_q        <= 1'b0;
         lose_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         fish_y_q     <= fish_y_d;
         fish_w_q     <= fish_w_d;
         fish_speed_q <= fish_speed_d;
         spawn_q      <= spawn_d;
         play_en_q    <= play_en_d;
         time_left_q  <= time_left_d;
         misses_q     <= misses_d;
         score_q      <= score_d;
         win_q        <= win_d;
         lose_q       <= lose_d;
      end
   end

   assign level      = level_q;
   assign fish_y     = fish_y_q;
   assign fish_w     = fish_w_q;
   assign fish_speed = fish_speed_q;
   assign spawn      = spawn_q;
   assign play_en    = play_en_q;
   assign time_left  = time_left_q;
   assign misses     = misses_q;
   assign score      = score_q;
   assign win        = win_q;
   assign lose       = lose_q;

endmodule

// File: tb/tb_fish_round_sequencer.sv
// Bench for fish_round_sequencer: vector table plus hand-written corner
// sequences; a second instance with LEVEL_TIME=127 exercises score saturation.
module tb_fish_round_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0, start = 1'b0, hooked = 1'b0, landed = 1'b0, escaped = 1'b0;
`ifdef FISH_PAUSE_EN
   logic pause = 1'b0;
`endif

   logic [1:0] level_a, level_b;
   logic [9:0] fish_y_a, fish_y_b;
   logic [5:0] fish_w_a, fish_w_b;
   logic [2:0] fish_speed_a, fish_speed_b;
   logic       spawn_a, spawn_b, play_en_a, play_en_b;
   logic [6:0] time_left_a, time_left_b;
   logic [2:0] misses_a, misses_b;
   logic [7:0] score_a, score_b;
   logic       win_a, win_b, lose_a, lose_b;

   int n_checks = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fish_round_sequencer u_dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start),
      .hooked(hooked), .landed(landed), .escaped(escaped),
`ifdef FISH_PAUSE_EN
      .pause(pause),
`endif
      .level(level_a), .fish_y(fish_y_a), .fish_w(fish_w_a), .fish_speed(fish_speed_a),
      .spawn(spawn_a), .play_en(play_en_a), .time_left(time_left_a), .misses(misses_a),
      .score(score_a), .win(win_a), .lose(lose_a)
   );

   fish_round_sequencer #(.TICKS_PER_SEC(60), .LEVEL_TIME(127), .MAX_MISSES(3)) u_sat (
      .clk(clk), .rst(rst), .tick(tick), .start(start),
      .hooked(hooked), .landed(landed), .escaped(escaped),
`ifdef FISH_PAUSE_EN
      .pause(pause),
`endif
      .level(level_b), .fish_y(fish_y_b), .fish_w(fish_w_b), .fish_speed(fish_speed_b),
      .spawn(spawn_b), .play_en(play_en_b), .time_left(time_left_b), .misses(misses_b),
      .score(score_b), .win(win_b), .lose(lose_b)
   );

   typedef struct {
      string name;
      int rs, st, hk, ld, es, tk, n;
      int lvl, fy, fw, fs, tl, mis, sc, sp, pe, wn, ls;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   sc_q[$];

   function automatic vec_t mk(string nm, int rs, int st, int hk, int ld, int es, int tk, int n,
                               int lvl, int tl, int mis, int sc, int sp, int pe, int wn, int ls);
      vec_t v;
      int fy_t[4] = '{470, 380, 290, 200};
      int fw_t[4] = '{60, 40, 20, 10};
      int fs_t[4] = '{1, 2, 3, 4};
      v.name = nm; v.rs = rs; v.st = st; v.hk = hk; v.ld = ld; v.es = es; v.tk = tk; v.n = n;
      v.lvl = lvl; v.fy = fy_t[lvl]; v.fw = fw_t[lvl]; v.fs = fs_t[lvl];
      v.tl = tl; v.mis = mis; v.sc = sc; v.sp = sp; v.pe = pe; v.wn = wn; v.ls = ls;
      return v;
   endfunction

   function automatic void chk(string nm, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic compare_a(input vec_t e);
      chk({e.name, ".level"}, int'(level_a), e.lvl);
      chk({e.name, ".fish_y"}, int'(fish_y_a), e.fy);
      chk({e.name, ".fish_w"}, int'(fish_w_a), e.fw);
      chk({e.name, ".fish_speed"}, int'(fish_speed_a), e.fs);
      chk({e.name, ".time_left"}, int'(time_left_a), e.tl);
      chk({e.name, ".misses"}, int'(misses_a), e.mis);
      chk({e.name, ".score"}, int'(score_a), e.sc);
      chk({e.name, ".spawn"}, int'(spawn_a), e.sp);
      chk({e.name, ".play_en"}, int'(play_en_a), e.pe);
      chk({e.name, ".win"}, int'(win_a), e.wn);
      chk({e.name, ".lose"}, int'(lose_a), e.ls);
   endtask

   task automatic reset_and_start();
      rst = 1'b1; cyc(); rst = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      cyc();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t e;
      int exp_a, exp_b;
      //           name         rs st hk ld es tk n     lvl tl mis sc sp pe wn ls
      vecs.push_back(mk("reset",     1, 0, 0, 0, 0, 0, 1,    0, 30, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("start",     0, 1, 0, 0, 0, 0, 1,    0, 30, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk("play",      0, 0, 0, 0, 0, 0, 1,    0, 30, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk("sec1",      0, 0, 0, 0, 0, 1, 60,   0, 29, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk("ignored",   0, 1, 0, 1, 1, 0, 1,    0, 29, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk("t1799",     0, 0, 0, 0, 0, 1, 1739, 0, 1, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk("timeout",   0, 0, 0, 0, 0, 1, 1,    0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk("lose_hold", 0, 0, 1, 0, 0, 1, 10,   0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk("restart",   0, 1, 0, 0, 0, 0, 1,    0, 30, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk("play2",     0, 0, 0, 0, 0, 0, 1,    0, 30, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk("t300",      0, 0, 0, 0, 0, 1, 300,  0, 25, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk("hook",      0, 0, 1, 0, 0, 0, 1,    0, 25, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk("reel_frz",  0, 0, 0, 0, 0, 1, 10,   0, 25, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk("land",      0, 0, 0, 1, 0, 0, 1,    0, 25, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("next1",     0, 0, 0, 0, 0, 0, 1,    1, 30, 0, 25, 1, 0, 0, 0));
      vecs.push_back(mk("play3",     0, 0, 0, 0, 0, 0, 1,    1, 30, 0, 25, 0, 1, 0, 0));
      vecs.push_back(mk("hook2",     0, 0, 1, 0, 0, 0, 1,    1, 30, 0, 25, 0, 1, 0, 0));
      vecs.push_back(mk("land_esc",  0, 0, 0, 1, 1, 0, 1,    1, 30, 0, 25, 0, 0, 0, 0));
      vecs.push_back(mk("next2",     0, 0, 0, 0, 0, 0, 1,    2, 30, 0, 55, 1, 0, 0, 0));
      vecs.push_back(mk("play4",     0, 0, 0, 0, 0, 0, 1,    2, 30, 0, 55, 0, 1, 0, 0));
      vecs.push_back(mk("t90",       0, 0, 0, 0, 0, 1, 90,   2, 29, 0, 55, 0, 1, 0, 0));
      vecs.push_back(mk("hook3",     0, 0, 1, 0, 0, 0, 1,    2, 29, 0, 55, 0, 1, 0, 0));
      vecs.push_back(mk("esc1",      0, 0, 0, 0, 1, 0, 1,    2, 29, 1, 55, 1, 0, 0, 0));
      vecs.push_back(mk("play5",     0, 0, 0, 0, 0, 0, 1,    2, 29, 1, 55, 0, 1, 0, 0));
      vecs.push_back(mk("t30",       0, 0, 0, 0, 0, 1, 30,   2, 28, 1, 55, 0, 1, 0, 0));
      vecs.push_back(mk("hook4",     0, 0, 1, 0, 0, 0, 1,    2, 28, 1, 55, 0, 1, 0, 0));
      vecs.push_back(mk("esc2",      0, 0, 0, 0, 1, 0, 1,    2, 28, 2, 55, 1, 0, 0, 0));
      vecs.push_back(mk("play6",     0, 0, 0, 0, 0, 0, 1,    2, 28, 2, 55, 0, 1, 0, 0));
      vecs.push_back(mk("hook5",     0, 0, 1, 0, 0, 0, 1,    2, 28, 2, 55, 0, 1, 0, 0));
      vecs.push_back(mk("esc3",      0, 0, 0, 0, 1, 0, 1,    2, 28, 3, 55, 0, 0, 0, 1));
      vecs.push_back(mk("restart2",  0, 1, 0, 0, 0, 0, 1,    0, 30, 0, 0, 1, 0, 0, 0));

      #2;
      foreach (vecs[i]) begin
         rst = vecs[i].rs[0]; start = vecs[i].st[0]; hooked = vecs[i].hk[0];
         landed = vecs[i].ld[0]; escaped = vecs[i].es[0]; tick = vecs[i].tk[0];
         exp_q.push_back(vecs[i]);
         repeat (vecs[i].n) cyc();
         rst = 1'b0; start = 1'b0; hooked = 1'b0; landed = 1'b0; escaped = 1'b0; tick = 1'b0;
         e = exp_q.pop_front();
         compare_a(e);
         $display("vec %0d %s: level=%0d time_left=%0d misses=%0d score=%0d win=%0d lose=%0d",
                  i, e.name, level_a, time_left_a, misses_a, score_a, win_a, lose_a);
      end

      // Four quick landings: DUT A scores 30 per round, DUT B (127 s) saturates.
      reset_and_start();
      for (int r = 0; r < 4; r++) begin
         hooked = 1'b1; cyc(); hooked = 1'b0;
         landed = 1'b1;
         exp_a = 30 * (r + 1);
         exp_b = (127 * (r + 1) > 255) ? 255 : 127 * (r + 1);
         sc_q.push_back(exp_a);
         sc_q.push_back(exp_b);
         cyc(); landed = 1'b0;
         cyc();
         chk("round.score_a", int'(score_a), sc_q.pop_front());
         chk("round.score_b", int'(score_b), sc_q.pop_front());
         chk("round.level", int'(level_a), (r < 3) ? r + 1 : 3);
         if (r < 3) begin
            chk("round.spawn", int'(spawn_a), 1);
            cyc();
         end else begin
            chk("final.win_a", int'(win_a), 1);
            chk("final.win_b", int'(win_b), 1);
         end
         $display("round %0d: score_a=%0d score_b=%0d level=%0d win=%0d",
                  r, score_a, score_b, level_a, win_a);
      end
      start = 1'b1; cyc(); start = 1'b0;
      chk("win_restart.win", int'(win_a), 0);
      chk("win_restart.spawn", int'(spawn_a), 1);
      chk("win_restart.score", int'(score_a), 0);
      chk("win_restart.level", int'(level_a), 0);
      $display("win restart: level=%0d score=%0d spawn=%0d", level_a, score_a, spawn_a);

      // Asynchronous reset in the middle of a round.
      cyc();
      hooked = 1'b1; cyc(); hooked = 1'b0;
      landed = 1'b1; cyc(); landed = 1'b0;
      cyc();
      chk("pre_rst.level", int'(level_a), 1);
      rst = 1'b1;
      #2;
      chk("async_rst.level", int'(level_a), 0);
      chk("async_rst.spawn", int'(spawn_a), 0);
      chk("async_rst.fish_y", int'(fish_y_a), 470);
      chk("async_rst.score", int'(score_a), 0);
      $display("async reset: level=%0d spawn=%0d score=%0d", level_a, spawn_a, score_a);
      rst = 1'b0;

      // Hook arrives on the very tick that would time out: REEL wins.
      reset_and_start();
      tick = 1'b1;
      repeat (1799) cyc();
      chk("pre_timeout.time_left", int'(time_left_a), 1);
      hooked = 1'b1; cyc(); hooked = 1'b0;
      chk("hook_vs_timeout.lose", int'(lose_a), 0);
      chk("hook_vs_timeout.play_en", int'(play_en_a), 1);
      chk("hook_vs_timeout.time_left", int'(time_left_a), 1);
      repeat (5) cyc();
      tick = 1'b0;
      chk("reel_hold.time_left", int'(time_left_a), 1);
      chk("reel_hold.lose", int'(lose_a), 0);
      landed = 1'b1; cyc(); landed = 1'b0;
      cyc();
      chk("late_land.score", int'(score_a), 1);
      chk("late_land.level", int'(level_a), 1);
      $display("hook vs timeout: lose=%0d score=%0d level=%0d", lose_a, score_a, level_a);

`ifdef FISH_PAUSE_EN
      reset_and_start();
      tick = 1'b1;
      repeat (60) cyc();
      chk("pre_pause.time_left", int'(time_left_a), 29);
      pause = 1'b1;
      hooked = 1'b1; cyc(); hooked = 1'b0;
      repeat (119) cyc();
      chk("pause.time_left", int'(time_left_a), 29);
      chk("pause.play_en", int'(play_en_a), 0);
      pause = 1'b0;
      repeat (60) cyc();
      chk("resume.time_left", int'(time_left_a), 28);
      chk("resume.play_en", int'(play_en_a), 1);
      tick = 1'b0;
      $display("pause: time_left=%0d play_en=%0d", time_left_a, play_en_a);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
